// File: rtl/utils_pkg.sv
// utils_pkg: shared types and helpers for the nox reset/boot sequencer.
// The state enum lives here so that debug decode of state_o (in the top
// level and in benches) uses the same codes as the sequencer itself.
package utils_pkg;

    // Sequencer state codes; these values appear unchanged on state_o.
    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        HOLD      = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } rst_seq_st_t;

    // Ceiling of the saturating relock counter.
    localparam logic [7:0] RELOCK_MAX = 8'hFF;

    // Larger of two unsigned values, used to size the shared counter.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/nox_sync_ff.sv
// nox_sync_ff: STAGES-deep synchronizer for one asynchronous level input.
// Asynchronous active-low reset clears every stage to 0. The register
// vector carries ASYNC_REG so placement keeps the stages together and
// timing treats the first stage as the asynchronous capture point.
module nox_sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic arst_n,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

    // Shift the raw input through the synchronizer chain.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/nox_rst_seq.sv
// nox_rst_seq: reset/boot sequencer between the board PLL and the nox core.
// Runs on the free-running board clock so it keeps working while the PLL
// is unlocked. Order guaranteed: PLL reset pulse, wait for lock, lock
// stability window, core reset release, fetch delay, start_fetch.
//
// Valid/ready: no handshakes here; every output is a level, registered
// and decoded from the next state so it changes on the same edge as
// state_o.
//
// Optional button debounce: define NOX_RST_SEQ_DEBOUNCE_EN. Without it the
// rising edge of the synchronized button is the reset event directly.
module nox_rst_seq
    import utils_pkg::*;
#(
    parameter int unsigned SYNC_STAGES        = 2,
    parameter int unsigned PLL_RST_CYCLES     = 8,
    parameter int unsigned LOCK_TIMEOUT       = 1000000,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned FETCH_DELAY        = 16,
    parameter int unsigned DEBOUNCE_CYCLES    = 65536
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       pll_locked_i,
    input  logic       btn_rst_i,
    output logic       pll_rst_o,
    output logic       rst_cpu_o,
    output logic       start_fetch_o,
    output logic [2:0] state_o,
    output logic [7:0] relock_cnt_o
);

    // One counter serves every timed state; sized for the longest window.
    localparam int unsigned CNT_MAX = max_u(max_u(PLL_RST_CYCLES, LOCK_TIMEOUT),
                                            max_u(LOCK_STABLE_CYCLES, FETCH_DELAY));
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

    // A state lasting N cycles leaves when the counter shows N-1.
    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] FETCH_LAST   = CNT_W'(FETCH_DELAY - 1);
    localparam logic [CNT_W-1:0] CNT_SAT      = '1;

    rst_seq_st_t      state_q;
    rst_seq_st_t      state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pll_rst_d;
    logic             rst_cpu_d;
    logic             start_fetch_d;
    logic [7:0]       relock_d;
    logic             relock_inc;

    logic             lock_s;
    logic             btn_s;
    logic             btn_evt;

    nox_sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync_lock (
        .clk    (clk),
        .arst_n (arst_n),
        .d      (pll_locked_i),
        .q      (lock_s)
    );

    nox_sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync_btn (
        .clk    (clk),
        .arst_n (arst_n),
        .d      (btn_rst_i),
        .q      (btn_s)
    );

`ifdef NOX_RST_SEQ_DEBOUNCE_EN
    // db_level_q is the accepted button level; the button only counts as
    // pressed after btn_s has differed from it for DEBOUNCE_CYCLES cycles,
    // and only re-arms after the same window of btn_s=0.
    localparam int unsigned     DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [DB_W-1:0] db_cnt_q;
    logic            db_level_q;
    logic            db_flip;

    assign db_flip = (btn_s != db_level_q) && (db_cnt_q == DB_LAST);
    assign btn_evt = db_flip && btn_s;

    // Count how long btn_s has disagreed with the accepted level.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            db_cnt_q   <= '0;
            db_level_q <= 1'b0;
        end else begin
            if ((btn_s == db_level_q) || db_flip) begin
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + DB_W'(1);
            end
            if (db_flip) begin
                db_level_q <= btn_s;
            end
        end
    end
`else
    // The debounce window has no effect in this build.
    localparam int unsigned unused_debounce_cycles = DEBOUNCE_CYCLES;

    logic btn_q;

    // Remember the previous synchronized button level for edge detection.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            btn_q <= 1'b0;
        end else begin
            btn_q <= btn_s;
        end
    end

    assign btn_evt = btn_s && !btn_q;
`endif

    // Next state, shared counter, and output decode from the next state.
    // Priority: button event, then lock loss, then counter expiry.
    always_comb begin
        state_d    = state_q;
        relock_inc = 1'b0;

        if (btn_evt && (state_q != PLL_RST)) begin
            state_d = PLL_RST;
        end else begin
            case (state_q)
                PLL_RST: begin
                    if (cnt_q == PLL_RST_LAST) begin
                        state_d = WAIT_LOCK;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = HOLD;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_d = PLL_RST;
                    end
                end
                HOLD: begin
                    // A lock glitch before the core is released is not a relock.
                    if (!lock_s) begin
                        state_d = WAIT_LOCK;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = RELEASE;
                    end
                end
                RELEASE: begin
                    if (!lock_s) begin
                        state_d    = WAIT_LOCK;
                        relock_inc = 1'b1;
                    end else if (cnt_q == FETCH_LAST) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state_d    = WAIT_LOCK;
                        relock_inc = 1'b1;
                    end
                end
                default: begin
                    state_d = PLL_RST;
                end
            endcase
        end

        // Cleared on every state entry; parks at all-ones in RUN.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        pll_rst_d     = (state_d == PLL_RST);
        rst_cpu_d     = !((state_d == RELEASE) || (state_d == RUN));
        start_fetch_d = (state_d == RUN);

        if (relock_inc && (relock_cnt_o != RELOCK_MAX)) begin
            relock_d = relock_cnt_o + 8'd1;
        end else begin
            relock_d = relock_cnt_o;
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q       <= PLL_RST;
            cnt_q         <= '0;
            pll_rst_o     <= 1'b1;
            rst_cpu_o     <= 1'b1;
            start_fetch_o <= 1'b0;
            relock_cnt_o  <= 8'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pll_rst_o     <= pll_rst_d;
            rst_cpu_o     <= rst_cpu_d;
            start_fetch_o <= start_fetch_d;
            relock_cnt_o  <= relock_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_nox_rst_seq.sv
// tb_nox_rst_seq: randomized and directed stimulus for nox_rst_seq with a
// reference model that tracks phase occupancy and input delay lines. The
// model pushes the expected output vector on every clock or reset event;
// a monitor pops and compares it one time unit later.
module tb_nox_rst_seq;
    import utils_pkg::*;

    localparam int SYNC = 2;
    localparam int PRC  = 2;
    localparam int LTO  = 20;
    localparam int LSC  = 4;
    localparam int FD   = 4;
    localparam int DEB  = 8;
    localparam int W    = 14;

    localparam int P_PLL  = int'(PLL_RST);
    localparam int P_WAIT = int'(WAIT_LOCK);
    localparam int P_HOLD = int'(HOLD);
    localparam int P_REL  = int'(RELEASE);
    localparam int P_RUN  = int'(RUN);

`ifdef NOX_RST_SEQ_DEBOUNCE_EN
    localparam int EXP_RELOCK_BTN = 2;
`else
    localparam int EXP_RELOCK_BTN = 1;
`endif

    // ---------------- clock / reset ----------------
    logic       clk          = 1'b0;
    logic       arst_n       = 1'b1;
    logic       pll_locked_i = 1'b0;
    logic       btn_rst_i    = 1'b0;
    logic       pll_rst_o;
    logic       rst_cpu_o;
    logic       start_fetch_o;
    logic [2:0] state_o;
    logic [7:0] relock_cnt_o;

    always #5 clk = ~clk;

    nox_rst_seq #(
        .SYNC_STAGES        (SYNC),
        .PLL_RST_CYCLES     (PRC),
        .LOCK_TIMEOUT       (LTO),
        .LOCK_STABLE_CYCLES (LSC),
        .FETCH_DELAY        (FD),
        .DEBOUNCE_CYCLES    (DEB)
    ) dut (
        .clk           (clk),
        .arst_n        (arst_n),
        .pll_locked_i  (pll_locked_i),
        .btn_rst_i     (btn_rst_i),
        .pll_rst_o     (pll_rst_o),
        .rst_cpu_o     (rst_cpu_o),
        .start_fetch_o (start_fetch_o),
        .state_o       (state_o),
        .relock_cnt_o  (relock_cnt_o)
    );

    int n_checks = 0;
    int n_fails  = 0;
    logic [W-1:0] exp_q[$];

    // ---------------- reference model ----------------
    int          m_phase;
    int          m_occ;
    int          m_relock;
    int          hi_run;
    int          lo_run;
    bit          armed;
    logic [SYNC:0] lock_d;
    logic [SYNC:0] btn_d;

    task automatic model_reset();
        m_phase  = P_PLL;
        m_occ    = 0;
        m_relock = 0;
        hi_run   = 0;
        lo_run   = 0;
        armed    = 1'b1;
        lock_d   = '0;
        btn_d    = '0;
    endtask

    task automatic model_step();
        logic ls;
        logic bs;
        logic bprev;
        logic bev;
        int   nxt;
        ls    = lock_d[SYNC-1];
        bs    = btn_d[SYNC-1];
        bprev = btn_d[SYNC];
`ifdef NOX_RST_SEQ_DEBOUNCE_EN
        bev = 1'b0;
        if (bs) begin
            hi_run++;
            lo_run = 0;
            if (armed && hi_run == DEB) begin
                bev   = 1'b1;
                armed = 1'b0;
            end
        end else begin
            lo_run++;
            hi_run = 0;
            if (!armed && lo_run == DEB) armed = 1'b1;
        end
`else
        bev = bs && !bprev;
`endif
        m_occ++;
        nxt = m_phase;
        if (bev && m_phase != P_PLL) begin
            nxt = P_PLL;
        end else if (m_phase == P_PLL) begin
            if (m_occ >= PRC) nxt = P_WAIT;
        end else if (m_phase == P_WAIT) begin
            if (ls) nxt = P_HOLD;
            else if (m_occ >= LTO) nxt = P_PLL;
        end else if (m_phase == P_HOLD) begin
            if (!ls) nxt = P_WAIT;
            else if (m_occ >= LSC) nxt = P_REL;
        end else begin
            if (!ls) begin
                nxt      = P_WAIT;
                m_relock = (m_relock < 255) ? m_relock + 1 : 255;
            end else if (m_phase == P_REL && m_occ >= FD) begin
                nxt = P_RUN;
            end
        end
        if (nxt != m_phase) m_occ = 0;
        m_phase = nxt;
        lock_d  = {lock_d[SYNC-1:0], pll_locked_i};
        btn_d   = {btn_d[SYNC-1:0], btn_rst_i};
    endtask

    function automatic logic [W-1:0] model_out();
        logic [2:0] st;
        logic [7:0] rc;
        st = 3'(m_phase);
        rc = 8'(m_relock);
        return {(m_phase == P_PLL), (m_phase < P_REL), (m_phase == P_RUN), st, rc};
    endfunction

    // Model: update on every clock edge or async reset, push expectation.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge arst_n);
            if (!arst_n) model_reset();
            else model_step();
            exp_q.push_back(model_out());
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [W-1:0] got;
        logic [W-1:0] exp;
        forever begin
            @(posedge clk or negedge arst_n);
            #1;
            got = {pll_rst_o, rst_cpu_o, start_fetch_o, state_o, relock_cnt_o};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fails++;
                $display("FAIL scoreboard_empty @%0t: got %h, no expectation queued", $time, got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    n_fails++;
                    $display("FAIL outputs @%0t: got pll_rst=%b rst_cpu=%b fetch=%b state=%0d relock=%0d, expected pll_rst=%b rst_cpu=%b fetch=%b state=%0d relock=%0d",
                             $time, got[13], got[12], got[11], got[10:8], got[7:0],
                             exp[13], exp[12], exp[11], exp[10:8], exp[7:0]);
                end
            end
            n_checks++;
            if ((start_fetch_o && rst_cpu_o) || (pll_rst_o && !rst_cpu_o)) begin
                n_fails++;
                $display("FAIL invariant @%0t: got pll_rst=%b rst_cpu=%b fetch=%b, required fetch->!rst_cpu and pll_rst->rst_cpu",
                         $time, pll_rst_o, rst_cpu_o, start_fetch_o);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check_val(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic wait_phase(input int ph, input int budget, input string tag);
        int k;
        k = 0;
        while (m_phase != ph && k < budget) begin
            step(1);
            k++;
        end
        if (m_phase != ph) begin
            n_checks++;
            n_fails++;
            $display("FAIL wait_%s: phase %0d after %0d cycles, expected %0d", tag, m_phase, budget, ph);
        end
    endtask

    task automatic apply_reset();
        arst_n = 1'b0;
        step(2);
        arst_n = 1'b1;
    endtask

    // Called just after arst_n rises with the PLL locked.
    task automatic boot_check(input string tag);
        int pll_fall;
        int rst_fall;
        int fetch_rise;
        pll_fall   = -1;
        rst_fall   = -1;
        fetch_rise = -1;
        for (int k = 1; k <= 14; k++) begin
            step(1);
            if (pll_fall < 0 && !pll_rst_o) pll_fall = k;
            if (rst_fall < 0 && !rst_cpu_o) rst_fall = k;
            if (fetch_rise < 0 && start_fetch_o) fetch_rise = k;
        end
        check_val({tag, "_pll_rst_fall_edge"}, pll_fall, 2);
        check_val({tag, "_rst_cpu_fall_edge"}, rst_fall, 7);
        check_val({tag, "_start_fetch_rise_edge"}, fetch_rise, 11);
        check_val({tag, "_state_run"}, int'(state_o), 4);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lows;
        #1 arst_n = 1'b0;
        pll_locked_i = 1'b1;
        step(3);
        check_val("reset_state", int'({pll_rst_o, rst_cpu_o, start_fetch_o, state_o, relock_cnt_o}), int'(14'b110_000_00000000));

        // Boot with a steady lock.
        arst_n = 1'b1;
        boot_check("boot");

        // No lock at all: PLL reset keeps repeating, core stays in reset.
        pll_locked_i = 1'b0;
        apply_reset();
        lows = 0;
        for (int k = 0; k < 70; k++) begin
            step(1);
            if (!rst_cpu_o) lows++;
        end
        check_val("nolock_rst_cpu_low_cycles", lows, 0);

        // Lock glitch during HOLD: no relock count, core kept in reset.
        pll_locked_i = 1'b1;
        apply_reset();
        wait_phase(P_HOLD, 20, "hold");
        pll_locked_i = 1'b0;
        step(3);
        pll_locked_i = 1'b1;
        wait_phase(P_RUN, 60, "run_after_glitch");
        check_val("hold_glitch_relock", int'(relock_cnt_o), 0);

        // Repeated lock loss in RUN: relock counter saturates.
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 4));
            pll_locked_i = 1'b0;
            step($urandom_range(1, 3));
            pll_locked_i = 1'b1;
            wait_phase(P_WAIT, 10, "relock_wait");
            wait_phase(P_RUN, 60, "relock_run");
        end
        check_val("relock_saturated", int'(relock_cnt_o), 255);

        // Button coincident with lock loss in RUN.
        apply_reset();
        wait_phase(P_RUN, 40, "btn_run0");
        pll_locked_i = 1'b0;
        step(1);
        pll_locked_i = 1'b1;
        wait_phase(P_WAIT, 10, "btn_wait0");
        wait_phase(P_RUN, 60, "btn_run1");
        btn_rst_i    = 1'b1;
        pll_locked_i = 1'b0;
        step(2);
        btn_rst_i    = 1'b0;
        pll_locked_i = 1'b1;
        step(3);
        wait_phase(P_RUN, 80, "btn_run2");
        check_val("btn_vs_lockloss_relock", int'(relock_cnt_o), EXP_RELOCK_BTN);

        // Short and long button pulses in RUN.
        btn_rst_i = 1'b1;
        step(5);
        btn_rst_i = 1'b0;
        step(12);
`ifdef NOX_RST_SEQ_DEBOUNCE_EN
        check_val("short_pulse_ignored_state", int'(state_o), 4);
`endif
        wait_phase(P_RUN, 60, "btn_run3");
        btn_rst_i = 1'b1;
        step(10);
        btn_rst_i = 1'b0;
        step(12);
        wait_phase(P_RUN, 60, "btn_run4");

        // Asynchronous reset in the middle of RELEASE.
        apply_reset();
        wait_phase(P_REL, 40, "release");
        step(1);
        arst_n = 1'b0;
        #1;
        check_val("async_reset_outputs", int'({pll_rst_o, rst_cpu_o, start_fetch_o, state_o, relock_cnt_o}), int'(14'b110_000_00000000));
        step(2);
        arst_n = 1'b1;
        boot_check("reboot");

        // Random lock and button activity.
        for (int k = 0; k < 2000; k++) begin
            if (pll_locked_i) pll_locked_i = ($urandom_range(0, 39) != 0);
            else              pll_locked_i = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 63) == 0) btn_rst_i = ~btn_rst_i;
            step(1);
        end

        step(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
